// File: rtl/regfile_32x64.sv
// 32 x 64-bit general-purpose register file: one synchronous write port, two combinational read ports.
// Optional REGFILE_ZERO_REG_EN: register 31 becomes a hardwired zero register (XZR).
module regfile_32x64 #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rdAddrA,
    input  logic [ADDR_WIDTH-1:0] rdAddrB,
    output logic [DATA_WIDTH-1:0] rdDataA,
    output logic [DATA_WIDTH-1:0] rdDataB,
    input  logic [ADDR_WIDTH-1:0] wrAddr,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  write
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_en_c;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '1;

    // Writes aimed at XZR are dropped so its storage stays zero.
    assign wr_en_c = write && (wrAddr != ZERO_ADDR);
`else
    assign wr_en_c = write;
`endif

    // Storage: async clear, no bypass between write and read paths.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Zero-latency read ports.
    always_comb begin
        rdDataA = regs[rdAddrA];
        rdDataB = regs[rdAddrB];
`ifdef REGFILE_ZERO_REG_EN
        if (rdAddrA == ZERO_ADDR) rdDataA = '0;
        if (rdAddrB == ZERO_ADDR) rdDataB = '0;
`endif
    end

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed self-checking bench for regfile_32x64; expectations for r31 follow REGFILE_ZERO_REG_EN.
module tb_regfile_32x64;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic [63:0] rdDataA;
    logic [63:0] rdDataB;
    logic [4:0]  wrAddr;
    logic [63:0] wrData;
    logic        write;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [63:0] EXP_R31 = 64'h0;
`else
    localparam logic [63:0] EXP_R31 = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    regfile_32x64 dut (
        .clk     (clk),
        .reset   (reset),
        .rdAddrA (rdAddrA),
        .rdAddrB (rdAddrB),
        .rdDataA (rdDataA),
        .rdDataB (rdDataB),
        .wrAddr  (wrAddr),
        .wrData  (wrData),
        .write   (write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a write at the falling edge, let it commit on the next rising edge.
    task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
        @(negedge clk);
        wrAddr = addr;
        wrData = data;
        write  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic read_pair(input logic [4:0] a, input logic [4:0] b);
        rdAddrA = a;
        rdAddrB = b;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        write   = 1'b0;
        wrAddr  = 5'd0;
        wrData  = 64'h0;
        rdAddrA = 5'd0;
        rdAddrB = 5'd1;

        // Writes during reset must be ignored.
        #20;
        wrAddr = 5'd2;
        wrData = 64'h5555;
        write  = 1'b1;
        #20;
        write  = 1'b0;
        read_pair(5'd2, 5'd2);
        check("reset_hold_A", rdDataA, 64'h0);

        #57;
        reset = 1'b1;
        read_pair(5'd0, 5'd0);
        check("rst_r0_A", rdDataA, 64'h0);
        check("rst_r0_B", rdDataB, 64'h0);
        read_pair(5'd1, 5'd2);
        check("rst_r1_A", rdDataA, 64'h0);
        check("rst_r2_B", rdDataB, 64'h0);
        read_pair(5'd31, 5'd31);
        check("rst_r31_A", rdDataA, 64'h0);
        check("rst_r31_B", rdDataB, 64'h0);

        // Back-to-back writes on successive edges.
        do_write(5'd0, 64'h0000_0000_0000_FFFF);
        do_write(5'd1, 64'h0000_0000_0000_AAAA);
        do_write(5'd2, 64'h0000_0000_0000_CCCC);
        do_write(5'd3, 64'h0000_0000_0000_F0F0);
        @(negedge clk);
        write = 1'b0;
        read_pair(5'd0, 5'd1);
        check("wr_r0_A", rdDataA, 64'hFFFF);
        check("wr_r1_B", rdDataB, 64'hAAAA);
        read_pair(5'd2, 5'd3);
        check("wr_r2_A", rdDataA, 64'hCCCC);
        check("wr_r3_B", rdDataB, 64'hF0F0);

        // Write disabled: wrAddr/wrData changes must not land.
        wrAddr = 5'd1;
        wrData = 64'h1234;
        repeat (3) @(posedge clk);
        #1;
        read_pair(5'd1, 5'd0);
        check("wdis_r1_A", rdDataA, 64'hAAAA);
        check("wdis_r0_B", rdDataB, 64'hFFFF);

        // Same-address read/write: old value before the edge, new after.
        rdAddrA = 5'd5;
        rdAddrB = 5'd0;
        @(negedge clk);
        wrAddr = 5'd5;
        wrData = 64'hDEAD_BEEF_CAFE_F00D;
        write  = 1'b1;
        #1;
        check("rw_before_A", rdDataA, 64'h0);
        @(posedge clk);
        #1;
        check("rw_after_A", rdDataA, 64'hDEAD_BEEF_CAFE_F00D);
        @(negedge clk);
        write = 1'b0;
        read_pair(5'd5, 5'd5);
        check("same_A", rdDataA, 64'hDEAD_BEEF_CAFE_F00D);
        check("same_B", rdDataB, 64'hDEAD_BEEF_CAFE_F00D);

        // Register 31 and full-width pattern on r30.
        do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        do_write(5'd30, 64'h8000_0000_0000_0001);
        @(negedge clk);
        write = 1'b0;
        read_pair(5'd31, 5'd31);
        check("r31_A", rdDataA, EXP_R31);
        check("r31_B", rdDataB, EXP_R31);
        read_pair(5'd30, 5'd31);
        check("r30_A", rdDataA, 64'h8000_0000_0000_0001);

        // Register 0 write path reused for later async-reset check.
        read_pair(5'd0, 5'd3);
        check("pre_arst_r0", rdDataA, 64'hFFFF);
        check("pre_arst_r3", rdDataB, 64'hF0F0);

        // Async reset pulse between edges: outputs drop with no clock edge.
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_r0_A", rdDataA, 64'h0);
        check("arst_r3_B", rdDataB, 64'h0);
        reset = 1'b1;
        read_pair(5'd5, 5'd30);
        check("arst_r5_A", rdDataA, 64'h0);
        check("arst_r30_B", rdDataB, 64'h0);

        // First edge after release accepts a write.
        do_write(5'd4, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        write = 1'b0;
        read_pair(5'd4, 5'd1);
        check("post_arst_r4", rdDataA, 64'h0123_4567_89AB_CDEF);
        check("post_arst_r1", rdDataB, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
